// File: rtl/sum_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_acc_pkg
// Purpose  : Shared state encoding, default widths and saturation constant
//            for the windowed sum accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package sum_acc_pkg;

    localparam int C_DATA_W = 9;
    localparam int C_ACC_W  = 16;
    localparam int C_CNT_W  = 8;

    localparam logic [C_ACC_W-1:0] C_SAT_ONES = {C_ACC_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : sum_acc_pkg
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sat_add
// Purpose  : Combinational unsigned adder (ACC_W + zero-extended DATA_W)
//            that clamps to all-ones and flags overflow.
// Revision : 1.0 - initial release
// ============================================================================
module sat_add
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ACC_W  = C_ACC_W
) (
    input  logic [ACC_W-1:0]  i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W:0] w_full;

    // One extra bit of headroom exposes the carry out of the accumulator.
    assign w_full = {1'b0, i_a} + {{(ACC_W + 1 - DATA_W){1'b0}}, i_b};
    assign o_ovf  = w_full[ACC_W];
    assign o_sum  = o_ovf ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule : sat_add
`default_nettype wire

// File: rtl/sum_window_acc.sv
`default_nettype none
// ============================================================================
// Module   : sum_window_acc
// Purpose  : Accumulates a programmable window of valid adder sums into a
//            saturating total presented on a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module sum_window_acc
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ACC_W  = C_ACC_W,
    parameter int CNT_W  = C_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  win_len_i,
    input  logic [DATA_W-1:0] sum_i,
    input  logic              sum_valid_i,
    output logic              busy_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o,
    output logic              done_o,
    input  logic              done_ready_i
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W:0]     r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_done;
    logic               r_busy;
    logic               w_start;
    logic               w_acc_en;
    logic [ACC_W-1:0]   w_sat_sum;
    logic               w_sat_ovf;
    logic [CNT_W:0]     w_cnt_load;

    // A zero length sets the extra top bit, encoding 2^CNT_W samples.
    assign w_cnt_load = {(win_len_i == '0), win_len_i};

    sat_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .i_a    (r_acc),
        .i_b    (sum_i),
        .o_sum  (w_sat_sum),
        .o_ovf  (w_sat_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                if (sum_valid_i) begin
                    w_acc_en = 1'b1;
                    if (r_cnt == (CNT_W + 1)'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (done_ready_i) begin
                    if (start_i) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_ACC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_start) begin
                r_cnt <= w_cnt_load;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_acc_en) begin
                // Once saturated the sum stays all-ones, so only the flag needs holding.
                r_cnt <= r_cnt - (CNT_W + 1)'(1);
                r_acc <= w_sat_sum;
                r_ovf <= r_ovf | w_sat_ovf;
            end
        end
    end

    assign busy_o = r_busy;
    assign acc_o  = r_acc;
    assign ovf_o  = r_ovf;
    assign done_o = r_done;

endmodule : sum_window_acc
`default_nettype wire

// File: tb/tb_sum_window_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_window_acc
// Purpose  : Directed self-checking bench for sum_window_acc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_window_acc;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  win_len_i;
    logic [8:0]  sum_i;
    logic        sum_valid_i;
    logic        busy_o;
    logic [15:0] acc_o;
    logic        ovf_o;
    logic        done_o;
    logic        done_ready_i;

    int n_total = 0;
    int n_bad   = 0;

    sum_window_acc dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .win_len_i    (win_len_i),
        .sum_i        (sum_i),
        .sum_valid_i  (sum_valid_i),
        .busy_o       (busy_o),
        .acc_o        (acc_o),
        .ovf_o        (ovf_o),
        .done_o       (done_o),
        .done_ready_i (done_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] acc, input logic ovf,
                           input logic done, input logic busy);
        chk({tag, ".acc"},  32'(acc_o),  32'(acc));
        chk({tag, ".ovf"},  32'(ovf_o),  32'(ovf));
        chk({tag, ".done"}, 32'(done_o), 32'(done));
        chk({tag, ".busy"}, 32'(busy_o), 32'(busy));
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; win_len_i = '0; sum_i = '0;
        sum_valid_i = 1'b0; done_ready_i = 1'b0;
        tick(); tick();
        chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic window of 4
        start_i = 1'b1; win_len_i = 8'd4;
        tick();
        start_i = 1'b0;
        chk_all("basic_start", 16'h0000, 1'b0, 1'b0, 1'b1);
        sum_valid_i = 1'b1;
        sum_i = 9'h1FE; tick(); chk("basic_s1", 32'(acc_o), 32'h01FE);
        sum_i = 9'h001; tick(); chk("basic_s2", 32'(acc_o), 32'h01FF);
        sum_i = 9'h100; tick(); chk("basic_s3", 32'(acc_o), 32'h02FF);
        chk("basic_s3_done", 32'(done_o), 32'd0);
        sum_i = 9'h0FF; tick();
        sum_valid_i = 1'b0;
        chk_all("basic_final", 16'h03FE, 1'b0, 1'b1, 1'b1);
        done_ready_i = 1'b1; tick(); done_ready_i = 1'b0;
        chk_all("basic_hs", 16'h03FE, 1'b0, 1'b0, 1'b0);
        sum_valid_i = 1'b1; sum_i = 9'h055; tick(); sum_valid_i = 1'b0;
        chk_all("idle_ignore", 16'h03FE, 1'b0, 1'b0, 1'b0);

        // Gaps in valid, window of 3
        start_i = 1'b1; win_len_i = 8'd3;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sum_valid_i = 1'b1; sum_i = 9'h010;
            tick();
            sum_valid_i = 1'b0;
            if (i < 2) begin
                chk("gap_done_early", 32'(done_o), 32'd0);
                tick(); tick();
                chk("gap_hold", 32'(acc_o), 32'(16'h0010 * (i + 1)));
            end
        end
        chk_all("gap_final", 16'h0030, 1'b0, 1'b1, 1'b1);
        done_ready_i = 1'b1; tick(); done_ready_i = 1'b0;
        chk("gap_hs", 32'(busy_o), 32'd0);

        // Saturation with the 0 = 256 length encoding
        start_i = 1'b1; win_len_i = 8'd0;
        tick();
        start_i = 1'b0;
        sum_valid_i = 1'b1; sum_i = 9'h1FF;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 128) begin
                chk("sat_128_acc", 32'(acc_o), 32'd65408);
                chk("sat_128_ovf", 32'(ovf_o), 32'd0);
            end
            if (i == 129) begin
                chk("sat_129_acc", 32'(acc_o), 32'hFFFF);
                chk("sat_129_ovf", 32'(ovf_o), 32'd1);
            end
            if (i == 255) chk("sat_255_done", 32'(done_o), 32'd0);
        end
        sum_valid_i = 1'b0;
        chk_all("sat_final", 16'hFFFF, 1'b1, 1'b1, 1'b1);

        // Back-to-back: handshake and new start in the same cycle
        done_ready_i = 1'b1; start_i = 1'b1; win_len_i = 8'd2;
        tick();
        done_ready_i = 1'b0; start_i = 1'b0;
        chk_all("b2b_start", 16'h0000, 1'b0, 1'b0, 1'b1);
        sum_valid_i = 1'b1;
        sum_i = 9'h005; tick(); chk("b2b_s1", 32'(acc_o), 32'h0005);
        sum_i = 9'h007; tick();
        sum_valid_i = 1'b0;
        chk_all("b2b_final", 16'h000C, 1'b0, 1'b1, 1'b1);

        // Backpressure in DONE with sum_valid and start driven
        sum_valid_i = 1'b1; sum_i = 9'h123; start_i = 1'b1; win_len_i = 8'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("bp_hold", 16'h000C, 1'b0, 1'b1, 1'b1);
        end
        sum_valid_i = 1'b0; start_i = 1'b0; done_ready_i = 1'b1;
        tick();
        done_ready_i = 1'b0;
        chk_all("bp_release", 16'h000C, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a window
        start_i = 1'b1; win_len_i = 8'd4;
        tick();
        start_i = 1'b0;
        sum_valid_i = 1'b1; sum_i = 9'h010;
        tick(); tick();
        sum_valid_i = 1'b0;
        chk("mid_acc", 32'(acc_o), 32'h0020);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        start_i = 1'b1; win_len_i = 8'd1;
        tick();
        start_i = 1'b0;
        sum_valid_i = 1'b1; sum_i = 9'h0AA;
        tick();
        sum_valid_i = 1'b0;
        chk_all("post_rst", 16'h00AA, 1'b0, 1'b1, 1'b1);
        done_ready_i = 1'b1; tick(); done_ready_i = 1'b0;
        chk("post_rst_hs", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_sum_window_acc
`default_nettype wire
